// File: rtl/async_fifo_pkg.sv
// Shared parameters and width helpers for the async FIFO read-side drain.
// Pure constants and constant functions; no logic or state.
package async_fifo_pkg;

    localparam int DATAWIDTH_DEF = 16;
    localparam int RD_LAT_DEF    = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width able to hold the values 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/async_fifo_rd_buf.sv
// Synchronous first-word-fall-through buffer: head always shows the oldest entry.
// Latency: a word pushed on an edge is visible at head after that edge.
// Backpressure: none internally; the producer must never push into a full buffer without a pop.
module async_fifo_rd_buf
    import async_fifo_pkg::*;
#(
    parameter int DW    = DATAWIDTH_DEF,
    parameter int DEPTH = RD_LAT_DEF + 2,
    localparam int LW   = lvl_w(DEPTH),
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge rclk) disable iff (rrst)
        !(push && !pop && level == LW'(DEPTH)));
    a_no_underflow: assert property (@(posedge rclk) disable iff (rrst)
        !(pop && level == '0));

endmodule

// File: rtl/async_fifo_rd_drain.sv
// Drains the read side of the async FIFO into a valid/ready stream, with an incrementing-sequence checker.
// Latency: first word reaches m_valid RD_LAT+1 cycles after its ren; 1 word/cycle sustained.
// Backpressure: ren is credit-gated on in-flight + buffered words, so m_ready low stalls pops without loss.
module async_fifo_rd_drain
    import async_fifo_pkg::*;
#(
    parameter int                   DATAWIDTH = DATAWIDTH_DEF,
    parameter int                   RD_LAT    = RD_LAT_DEF,
    parameter int                   BUF_DEPTH = RD_LAT + 2,
    parameter logic [DATAWIDTH-1:0] SEQ_INIT  = '0,
    parameter int                   CNT_W     = 32,
    localparam int                  LVL_W     = lvl_w(BUF_DEPTH)
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rempty,
    input  logic [DATAWIDTH-1:0] rdata,
    output logic                 ren,
    output logic                 m_valid,
    output logic [DATAWIDTH-1:0] m_data,
    input  logic                 m_ready,
    input  logic                 chk_en,
    output logic                 err_seq,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     word_cnt,
    output logic [LVL_W-1:0]     buf_level
);

    localparam int SUM_W = lvl_w(BUF_DEPTH + RD_LAT);

    logic [RD_LAT-1:0]    inflight;
    logic [SUM_W-1:0]     used;
    logic [DATAWIDTH-1:0] exp_val;
    logic                 hs;

    // Credits depend only on registered state and rempty, never on m_ready.
    always_comb begin
        used = SUM_W'(buf_level);
        for (int i = 0; i < RD_LAT; i++) used = used + SUM_W'(inflight[i]);
    end

    assign ren     = !rrst && !rempty && (used < SUM_W'(BUF_DEPTH));
    assign m_valid = (buf_level != '0);
    assign hs      = m_valid && m_ready;

    async_fifo_rd_buf #(
        .DW    (DATAWIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .rclk      (rclk),
        .rrst      (rrst),
        .push      (inflight[RD_LAT-1]),
        .push_data (rdata),
        .pop       (hs),
        .head      (m_data),
        .level     (buf_level)
    );

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            inflight   <= '0;
            err_seq    <= 1'b0;
            err_sticky <= 1'b0;
            word_cnt   <= '0;
            exp_val    <= SEQ_INIT;
        end else begin
            inflight[0] <= ren;
            for (int i = 1; i < RD_LAT; i++) inflight[i] <= inflight[i-1];
            err_seq <= 1'b0;
            if (hs) begin
                word_cnt <= word_cnt + 1'b1;
                // Resync to the observed word so a single drop reports once.
                exp_val  <= m_data + 1'b1;
                if (chk_en && (m_data != exp_val)) begin
                    err_seq    <= 1'b1;
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Directed bench for async_fifo_rd_drain with a queue model of the FIFO read port (RD_LAT = 1).
module tb_async_fifo_rd_drain;
    import async_fifo_pkg::*;

    localparam int DW = 16;
    localparam int LW = lvl_w(3);

    logic          rclk = 1'b0;
    logic          rrst = 1'b0;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          ren;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          chk_en = 1'b0;
    logic          err_seq;
    logic          err_sticky;
    logic [31:0]   word_cnt;
    logic [LW-1:0] buf_level;

    always #5 rclk = ~rclk;

    async_fifo_rd_drain dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rempty     (rempty),
        .rdata      (rdata),
        .ren        (ren),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .chk_en     (chk_en),
        .err_seq    (err_seq),
        .err_sticky (err_sticky),
        .word_cnt   (word_cnt),
        .buf_level  (buf_level)
    );

    // FIFO read-port model: one-cycle read latency, pointers share the drain reset.
    logic [DW-1:0] fmem [64];
    int            wr_idx = 0;
    int            rd_idx;

    assign rempty = (rd_idx == wr_idx);

    always @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rd_idx <= 0;
            rdata  <= '0;
        end else if (ren) begin
            rdata  <= fmem[rd_idx];
            rd_idx <= rd_idx + 1;
        end
    end

    typedef struct {
        logic          m_ready;
        logic          chk_en;
        logic          e_ren;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic [LW-1:0] e_level;
        int            e_cnt;
    } vec_t;

    vec_t          tbl [15];
    int            n_chk = 0;
    int            n_fail = 0;
    int            pulses = 0;
    logic [DW-1:0] got_q [$];
    logic [DW-1:0] exp_q [$];

    function automatic vec_t row(input logic rdy, input logic ce, input logic e_ren,
                                 input logic e_valid, input logic [DW-1:0] e_data,
                                 input logic [LW-1:0] e_level, input int e_cnt);
        vec_t v;
        v.m_ready = rdy;
        v.chk_en  = ce;
        v.e_ren   = e_ren;
        v.e_valid = e_valid;
        v.e_data  = e_data;
        v.e_level = e_level;
        v.e_cnt   = e_cnt;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] v);
        fmem[wr_idx] = v;
        wr_idx++;
    endtask

    // Called at a negedge; returns at a negedge with rrst still asserted.
    task automatic do_reset(input int cycles);
        rrst    = 1'b1;
        m_ready = 1'b0;
        chk_en  = 1'b0;
        wr_idx  = 0;
        repeat (cycles) @(negedge rclk);
    endtask

    task automatic run_rows(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            m_ready = tbl[r].m_ready;
            chk_en  = tbl[r].chk_en;
            #1;
            check($sformatf("row%0d_ren", r), 32'(ren), 32'(tbl[r].e_ren));
            check($sformatf("row%0d_valid", r), 32'(m_valid), 32'(tbl[r].e_valid));
            if (tbl[r].e_valid) check($sformatf("row%0d_data", r), 32'(m_data), 32'(tbl[r].e_data));
            check($sformatf("row%0d_level", r), 32'(buf_level), 32'(tbl[r].e_level));
            check($sformatf("row%0d_cnt", r), word_cnt, tbl[r].e_cnt);
            @(negedge rclk);
        end
    endtask

    // Collects handshakes until exp_q.size() words plus a few idle cycles, then compares.
    task automatic drain(input string nm, input bit toggle, input int budget);
        int tail;
        int n;
        logic [31:0] act;
        tail = 0;
        n    = exp_q.size();
        got_q.delete();
        for (int cyc = 0; cyc < budget; cyc++) begin
            m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (err_seq) pulses++;
            if (got_q.size() >= n) tail++;
            @(negedge rclk);
            if (tail >= 4) break;
        end
        m_ready = 1'b0;
        check({nm, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            act = (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_word%0d", nm, i), act, 32'(exp_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rens;

        // Single word (rows 0-3) then 8-word burst (rows 4-14), m_ready held high.
        tbl[0]  = row(1, 1, 1, 0, 16'h0, 2'd0, 0);
        tbl[1]  = row(1, 1, 0, 0, 16'h0, 2'd0, 0);
        tbl[2]  = row(1, 1, 0, 1, 16'h0, 2'd1, 0);
        tbl[3]  = row(1, 1, 0, 0, 16'h0, 2'd0, 1);
        tbl[4]  = row(1, 1, 1, 0, 16'h0, 2'd0, 0);
        tbl[5]  = row(1, 1, 1, 0, 16'h0, 2'd0, 0);
        tbl[6]  = row(1, 1, 1, 1, 16'h0, 2'd1, 0);
        tbl[7]  = row(1, 1, 1, 1, 16'h1, 2'd1, 1);
        tbl[8]  = row(1, 1, 1, 1, 16'h2, 2'd1, 2);
        tbl[9]  = row(1, 1, 1, 1, 16'h3, 2'd1, 3);
        tbl[10] = row(1, 1, 1, 1, 16'h4, 2'd1, 4);
        tbl[11] = row(1, 1, 1, 1, 16'h5, 2'd1, 5);
        tbl[12] = row(1, 1, 0, 1, 16'h6, 2'd1, 6);
        tbl[13] = row(1, 1, 0, 1, 16'h7, 2'd1, 7);
        tbl[14] = row(1, 1, 0, 0, 16'h0, 2'd0, 8);

        // Reset held 5 cycles with a word waiting in the FIFO.
        #1;
        @(negedge rclk);
        do_reset(1);
        load(16'h0000);
        repeat (5) @(negedge rclk);
        #1;
        check("rst_ren", 32'(ren), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_cnt", word_cnt, 0);
        check("rst_sticky", 32'(err_sticky), 0);
        check("rst_level", 32'(buf_level), 0);
        check("rst_data", 32'(m_data), 0);
        @(negedge rclk);
        rrst = 1'b0;
        run_rows(0, 3);

        // Burst 0..7 at full throughput.
        do_reset(2);
        for (int i = 0; i < 8; i++) load(DW'(i));
        rrst = 1'b0;
        run_rows(4, 14);
        #1;
        check("burst_sticky", 32'(err_sticky), 0);
        @(negedge rclk);

        // Backpressure: 10 words, m_ready low, then toggled.
        do_reset(2);
        for (int i = 0; i < 10; i++) load(DW'(i));
        chk_en = 1'b1;
        rrst   = 1'b0;
        rens   = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ren) rens++;
            @(negedge rclk);
        end
        #1;
        check("bp_pops", rens, 3);
        check("bp_level", 32'(buf_level), 3);
        check("bp_head", 32'(m_data), 0);
        @(negedge rclk);
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(DW'(i));
        pulses = 0;
        drain("bp", 1'b1, 80);
        check("bp_cnt", word_cnt, 10);
        check("bp_sticky", 32'(err_sticky), 0);
        check("bp_pulses", pulses, 0);

        // Wrap: unchecked resync word, then FFFE, FFFF, 0000 checked.
        do_reset(2);
        rrst   = 1'b0;
        pulses = 0;
        load(16'hFFFD);
        exp_q  = '{16'hFFFD};
        drain("resync1", 1'b0, 30);
        chk_en = 1'b1;
        load(16'hFFFE);
        load(16'hFFFF);
        load(16'h0000);
        exp_q  = '{16'hFFFE, 16'hFFFF, 16'h0000};
        drain("wrap", 1'b0, 30);
        check("wrap_pulses", pulses, 0);
        check("wrap_sticky", 32'(err_sticky), 0);

        // Dropped word: 5, 6, 8, 9 gives exactly one pulse.
        chk_en = 1'b0;
        load(16'h0004);
        exp_q  = '{16'h0004};
        drain("resync2", 1'b0, 30);
        chk_en = 1'b1;
        load(16'h0005);
        load(16'h0006);
        load(16'h0008);
        load(16'h0009);
        exp_q  = '{16'h0005, 16'h0006, 16'h0008, 16'h0009};
        drain("drop", 1'b0, 30);
        check("drop_pulses", pulses, 1);
        check("drop_sticky", 32'(err_sticky), 1);
        check("drop_cnt", word_cnt, 9);

        // Reset with 2 words buffered and 1 in flight.
        do_reset(2);
        for (int i = 0; i < 10; i++) load(DW'(i + 100));
        chk_en = 1'b1;
        rrst   = 1'b0;
        repeat (3) @(negedge rclk);
        #1;
        check("mid_level_before", 32'(buf_level), 2);
        rrst = 1'b1;
        #1;
        check("mid_ren", 32'(ren), 0);
        check("mid_valid", 32'(m_valid), 0);
        check("mid_level", 32'(buf_level), 0);
        check("mid_data", 32'(m_data), 0);
        check("mid_sticky", 32'(err_sticky), 0);
        @(negedge rclk);
        wr_idx = 0;
        @(negedge rclk);
        for (int i = 0; i < 3; i++) load(DW'(i));
        rrst   = 1'b0;
        pulses = 0;
        exp_q  = '{16'h0000, 16'h0001, 16'h0002};
        drain("refill", 1'b0, 30);
        check("refill_pulses", pulses, 0);
        check("refill_sticky", 32'(err_sticky), 0);
        check("refill_cnt", word_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
